// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the CPU run controller:
//                sequencer state encoding, memory byte strides and the
//                length-saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    // Byte distance between consecutive words of each memory.
    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    // Clamp a requested word count to the depth of the target memory.
    function automatic logic [10:0] sat_len(input logic [10:0] len, input logic [10:0] limit);
        return (len > limit) ? limit : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_controller_if
//  Description : Bundle of the program-load stream, the dump stream, the
//                core reset/enable and both external memory ports. The
//                controller uses the master view, host/memory the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_controller_if;
    // program load stream
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    // data dump stream
    logic        dp_valid;
    logic        dp_ready;
    logic [63:0] dp_data;
    // core control
    logic        cpu_arst_n;
    logic        cpu_enable;
    // instruction memory external port
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    // data memory external port
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  ld_valid, ld_data, dp_ready, rdata_ext_2,
        output ld_ready, dp_valid, dp_data, cpu_arst_n, cpu_enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2
    );

    modport slave (
        output ld_valid, ld_data, dp_ready, rdata_ext_2,
        input  ld_ready, dp_valid, dp_data, cpu_arst_n, cpu_enable,
               addr_ext, wen_ext, ren_ext, wdata_ext,
               addr_ext_2, wen_ext_2, ren_ext_2
    );
endinterface
`default_nettype wire

// File: rtl/stream_skid_out.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid_out
//  Description : Output holding register for a valid/ready stream. A word
//                is loaded, presented with valid, and held unchanged until
//                the consumer accepts it. Flush drops the word and clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_out #(
    parameter int DATA_W = 64
) (
    input  wire               clk,
    input  wire               arst,
    input  wire               flush,
    input  wire               load,
    input  wire  [DATA_W-1:0] in_data,
    input  wire               out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Flush beats load, load beats a drain; otherwise the word is held.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_controller
//  Description : Job sequencer for the pipelined core: streams a program
//                into instruction memory, runs the core for a fixed number
//                of cycles, freezes it, and streams a data-memory window out.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CYCLE_W    = 32
) (
    input  wire                  clk,
    input  wire                  arst,
    input  wire                  start,
    input  wire                  abort,
    input  wire  [9:0]           prog_len,
    input  wire  [CYCLE_W-1:0]   run_cycles,
    input  wire  [63:0]          dump_base,
    input  wire  [10:0]          dump_len,
    cpu_run_controller_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [CYCLE_W-1:0]   cycle_count
);
    import cpu_ctrl_pkg::*;

    localparam logic [9:0]         c_imem_limit = 10'(IMEM_WORDS);
    localparam logic [10:0]        c_dmem_limit = 11'(DMEM_WORDS);
    localparam logic [CYCLE_W-1:0] c_cnt_one    = CYCLE_W'(1);

    state_e             state_q, state_d;
    logic [9:0]         plen_q,  plen_d;
    logic [10:0]        dlen_q,  dlen_d;
    logic [CYCLE_W-1:0] run_q,   run_d;
    logic [63:0]        base_q,  base_d;
    logic [9:0]         idx_q,   idx_d;
    logic [10:0]        j_q,     j_d;
    logic [CYCLE_W-1:0] cnt_q,   cnt_d;

    logic        w_ld_fire;
    logic        w_run_live;
    logic        w_rd_fire;
    logic        w_dp_ready;
    logic        w_dp_valid;
    logic [63:0] w_dp_data;
    logic        w_dp_fire;
    state_e      w_after_run;

    assign w_ld_fire   = (state_q == ST_LOAD) && !abort && bus.ld_valid;
    assign w_run_live  = (state_q == ST_RUN) && (cnt_q != run_q);
    assign w_rd_fire   = (state_q == ST_DUMP_RD) && !abort;
    assign w_dp_ready  = (state_q == ST_DUMP_OUT) && bus.dp_ready;
    assign w_dp_fire   = w_dp_ready && w_dp_valid && !abort;
    assign w_after_run = (dlen_q != 11'd0) ? ST_DUMP_RD : ST_DONE;

    // Next-state, job-parameter and counter logic.
    always_comb begin
        state_d = state_q;
        plen_d  = plen_q;
        dlen_d  = dlen_q;
        run_d   = run_q;
        base_d  = base_q;
        idx_d   = idx_q;
        j_d     = j_q;
        cnt_d   = cnt_q;

        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            j_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        plen_d = 10'(sat_len({1'b0, prog_len}, {1'b0, c_imem_limit}));
                        dlen_d = sat_len(dump_len, c_dmem_limit);
                        run_d  = run_cycles;
                        base_d = dump_base;
                        idx_d  = '0;
                        j_d    = '0;
                        cnt_d  = '0;
                        // An empty program goes straight to the run phase.
                        state_d = (plen_d != 10'd0) ? ST_LOAD : ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        if (idx_q == plen_q - 10'd1) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + 10'd1;
                        end
                    end
                end
                ST_RUN: begin
                    // Leave on the edge that completes the budget so the
                    // enable window is exactly run_cycles long; a zero budget
                    // still spends one frozen cycle here.
                    if (cnt_q != run_q) begin
                        cnt_d = cnt_q + c_cnt_one;
                        if (cnt_d == run_q) begin
                            state_d = w_after_run;
                        end
                    end else begin
                        state_d = w_after_run;
                    end
                end
                ST_DUMP_RD: begin
                    state_d = ST_DUMP_OUT;
                end
                ST_DUMP_OUT: begin
                    if (w_dp_fire) begin
                        if (j_q == dlen_q - 11'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            j_d     = j_q + 11'd1;
                            state_d = ST_DUMP_RD;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            plen_q  <= '0;
            dlen_q  <= '0;
            run_q   <= '0;
            base_q  <= '0;
            idx_q   <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            plen_q  <= plen_d;
            dlen_q  <= dlen_d;
            run_q   <= run_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    // Dump word holder: captures the data-memory word as DUMP_RD ends.
    stream_skid_out #(
        .DATA_W (64)
    ) u_dp_skid (
        .clk       (clk),
        .arst      (arst),
        .flush     (abort),
        .load      (w_rd_fire),
        .in_data   (bus.rdata_ext_2),
        .out_ready (w_dp_ready),
        .out_valid (w_dp_valid),
        .out_data  (w_dp_data)
    );

    // Port decode from the registered state; memory strobes are forced low
    // outside their phases so the memories see a quiet bus.
    always_comb begin
        busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                      (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_OUT);
        done        = (state_q == ST_DONE);
        cycle_count = cnt_q;

        bus.ld_ready   = (state_q == ST_LOAD) && !abort;
        bus.wen_ext    = w_ld_fire;
        bus.addr_ext   = (state_q == ST_LOAD) ? 64'(idx_q) * 64'(IMEM_STRIDE) : 64'd0;
        bus.wdata_ext  = w_ld_fire ? bus.ld_data : 32'd0;
        bus.ren_ext    = 1'b0;

        bus.ren_ext_2  = w_rd_fire;
        bus.wen_ext_2  = 1'b0;
        bus.addr_ext_2 = (state_q == ST_DUMP_RD) ? base_q + 64'(j_q) * 64'(DMEM_STRIDE) : 64'd0;

        bus.dp_valid   = w_dp_valid;
        bus.dp_data    = w_dp_data;

        // The core leaves reset on the first RUN cycle and stays out of it,
        // frozen, until a new load begins or the job is abandoned.
        bus.cpu_arst_n = (state_q == ST_RUN) || (state_q == ST_DUMP_RD) ||
                         (state_q == ST_DUMP_OUT) || (state_q == ST_DONE);
        bus.cpu_enable = w_run_live;
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_controller
//  Description : Self-checking bench for cpu_run_controller: table of jobs
//                with hand-derived expectations, random jobs against a
//                word-count/address model, and abort/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;

    logic        clk = 1'b0;
    logic        arst;
    logic        start;
    logic        abort;
    logic [9:0]  prog_len;
    logic [31:0] run_cycles;
    logic [63:0] dump_base;
    logic [10:0] dump_len;
    logic        busy;
    logic        done;
    logic [31:0] cycle_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_run_controller_if bus ();

    cpu_run_controller #(
        .IMEM_WORDS (512),
        .DMEM_WORDS (1024),
        .CYCLE_W    (32)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .start       (start),
        .abort       (abort),
        .prog_len    (prog_len),
        .run_cycles  (run_cycles),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done),
        .cycle_count (cycle_count)
    );

    // Data memory contents are a fixed function of the address.
    function automatic logic [63:0] mem_f(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_0F0F, ~a[63:32]};
    endfunction

    // Word available while the read strobe is up; poison otherwise.
    assign bus.rdata_ext_2 = bus.ren_ext_2 ? mem_f(bus.addr_ext_2) : 64'hDEAD_BEEF_DEAD_BEEF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] dp_q[$];
    bit          mon_en = 1'b0;
    int          cyc = 0;
    int          en_cycles, en_runs, first_en, last_wr;
    bit          prev_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_dp;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.wen_ext) begin
                wr_q.push_back('{bus.addr_ext, bus.wdata_ext});
                last_wr = cyc;
            end
            if (bus.cpu_enable) begin
                en_cycles++;
                if (!prev_en) begin
                    en_runs++;
                    first_en = cyc;
                end
                chk("arst_n_while_enabled", 64'(bus.cpu_arst_n), 64'd1);
            end
            if (bus.ld_ready) chk("arst_n_while_loading", 64'(bus.cpu_arst_n), 64'd0);
            if (bus.ren_ext_2) rd_q.push_back(bus.addr_ext_2);
            if (bus.dp_valid && bus.dp_ready) dp_q.push_back(bus.dp_data);
            if (prev_stall) begin
                chk("dp_valid_held", 64'(bus.dp_valid), 64'd1);
                chk("dp_data_held", bus.dp_data, prev_dp);
            end
            chk("unused_strobes", 64'({bus.ren_ext, bus.wen_ext_2}), 64'd0);
        end
        prev_en    = mon_en && bus.cpu_enable;
        prev_stall = mon_en && bus.dp_valid && !bus.dp_ready;
        prev_dp    = bus.dp_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_busy"},       64'(busy), 64'd0);
        chk({t, "_done"},       64'(done), 64'd0);
        chk({t, "_cycle_count"}, 64'(cycle_count), 64'd0);
        chk({t, "_ld_ready"},   64'(bus.ld_ready), 64'd0);
        chk({t, "_wen_ext"},    64'(bus.wen_ext), 64'd0);
        chk({t, "_addr_ext"},   bus.addr_ext, 64'd0);
        chk({t, "_ren_ext_2"},  64'(bus.ren_ext_2), 64'd0);
        chk({t, "_addr_ext_2"}, bus.addr_ext_2, 64'd0);
        chk({t, "_dp_valid"},   64'(bus.dp_valid), 64'd0);
        chk({t, "_dp_data"},    bus.dp_data, 64'd0);
        chk({t, "_cpu_arst_n"}, 64'(bus.cpu_arst_n), 64'd0);
        chk({t, "_cpu_enable"}, 64'(bus.cpu_enable), 64'd0);
    endtask

    // Run one whole job and compare what the ports did with the model.
    // vmode: 0 = back-to-back words, 1 = random gaps.
    // rmode: 0 = always ready, 1 = random ready, 2 = first beat stalled 3 cycles.
    task automatic run_job(input string tag, input int plen, input logic [31:0] runc,
                           input logic [63:0] base, input int dlen,
                           input int exp_w, input int exp_d, input logic [63:0] exp_last,
                           input bit fixed, input int vmode, input int rmode);
        logic [31:0] prog[$];
        int wi = 0;
        int stall_left = 3;
        int budget;
        for (int k = 0; k < exp_w; k++) prog.push_back($urandom);
        if (fixed) begin
            prog[0] = 32'h0000_0013;
            prog[1] = 32'h0010_0093;
            prog[2] = 32'h0020_8113;
        end
        wr_q.delete(); rd_q.delete(); dp_q.delete();
        en_cycles = 0; en_runs = 0; first_en = -1; last_wr = -1;
        mon_en = 1'b1;
        prog_len   = 10'(plen);
        run_cycles = runc;
        dump_base  = base;
        dump_len   = 11'(dlen);
        start      = 1'b1;
        step();
        start = 1'b0;
        budget = 8 * exp_w + int'(runc) + 8 * exp_d + 40;
        while (!done && budget > 0) begin
            bus.ld_valid = 1'b0;
            if (bus.ld_ready && wi < exp_w) begin
                if (vmode == 0 || $urandom_range(0, 3) != 0) begin
                    bus.ld_valid = 1'b1;
                    bus.ld_data  = prog[wi];
                end
            end
            case (rmode)
                0: bus.dp_ready = 1'b1;
                1: bus.dp_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.dp_valid && stall_left > 0) begin
                        bus.dp_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.dp_ready = 1'b1;
                    end
                end
            endcase
            step();
            if (bus.ld_valid) wi++;
            budget--;
        end
        bus.ld_valid = 1'b0;
        bus.dp_ready = 1'b0;
        mon_en = 1'b0;
        chk({tag, "_done_reached"}, 64'(done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(runc));
        chk({tag, "_n_writes"}, 64'(wr_q.size()), 64'(exp_w));
        for (int k = 0; k < wr_q.size() && k < exp_w; k++) begin
            chk({tag, "_wr_addr"}, wr_q[k].a, 64'(4 * k));
            chk({tag, "_wr_data"}, 64'(wr_q[k].d), 64'(prog[k]));
        end
        if (exp_w > 0 && wr_q.size() > 0)
            chk({tag, "_last_wr_addr"}, wr_q[wr_q.size()-1].a, exp_last);
        chk({tag, "_enable_cycles"}, 64'(en_cycles), 64'(runc));
        chk({tag, "_enable_windows"}, 64'(en_runs), 64'(runc != 0));
        if (runc != 0 && exp_w > 0)
            chk({tag, "_run_after_load"}, 64'(first_en), 64'(last_wr + 1));
        chk({tag, "_n_reads"}, 64'(rd_q.size()), 64'(exp_d));
        chk({tag, "_n_beats"}, 64'(dp_q.size()), 64'(exp_d));
        for (int k = 0; k < exp_d; k++) begin
            if (k < rd_q.size()) chk({tag, "_rd_addr"}, rd_q[k], base + 64'(8 * k));
            if (k < dp_q.size()) chk({tag, "_beat_data"}, dp_q[k], mem_f(base + 64'(8 * k)));
        end
    endtask

    typedef struct {
        int          plen;
        logic [31:0] runc;
        logic [63:0] base;
        int          dlen;
        int          exp_w;
        int          exp_d;
        logic [63:0] exp_last;
        bit          fixed;
        int          vmode;
        int          rmode;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3,    32'd10, 64'h40,                  2,    3,   2,    64'h8,   1'b1, 0, 2};
        tbl[1] = '{1023, 32'd3,  64'h1000,                1,    512, 1,    64'h7FC, 1'b0, 0, 0};
        tbl[2] = '{0,    32'd5,  64'h0,                   3,    0,   3,    64'h0,   1'b0, 1, 1};
        tbl[3] = '{2,    32'd0,  64'hFFFF_FFFF_FFFF_FFF8, 3,    2,   3,    64'h4,   1'b0, 1, 0};
        tbl[4] = '{1,    32'd1,  64'h200,                 2047, 1,   1024, 64'h0,   1'b0, 0, 0};
        tbl[5] = '{512,  32'd2,  64'h8,                   0,    512, 0,    64'h7FC, 1'b0, 1, 1};

        arst = 1'b1; start = 1'b0; abort = 1'b0;
        prog_len = '0; run_cycles = '0; dump_base = '0; dump_len = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.dp_ready = 1'b0;
        #1;
        chk_idle("reset");
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        step();
        chk_idle("post_reset");

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i].plen, tbl[i].runc, tbl[i].base, tbl[i].dlen,
                    tbl[i].exp_w, tbl[i].exp_d, tbl[i].exp_last, tbl[i].fixed,
                    tbl[i].vmode, tbl[i].rmode);
        end

        // Empty job: RUN for one frozen cycle, then DONE.
        wr_q.delete(); rd_q.delete(); dp_q.delete();
        en_cycles = 0; en_runs = 0;
        mon_en = 1'b1;
        prog_len = '0; run_cycles = '0; dump_len = '0; dump_base = 64'h100;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("empty_busy_c1", 64'(busy), 64'd1);
        chk("empty_done_c1", 64'(done), 64'd0);
        step();
        chk("empty_done_c2", 64'(done), 64'd1);
        mon_en = 1'b0;
        chk("empty_no_strobes", 64'(wr_q.size() + rd_q.size() + dp_q.size() + en_cycles), 64'd0);

        // Abort after one of four words.
        prog_len = 10'd4; run_cycles = 32'd5; dump_len = 11'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'h1234_5678;
        step();
        bus.ld_valid = 1'b0;
        chk("abort_still_loading", 64'(bus.ld_ready), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort");
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        chk("abort_beats_start", 64'(busy), 64'd0);
        run_job("after_abort", 4, 32'd3, 64'h300, 2, 4, 2, 64'hC, 1'b0, 1, 1);

        // Asynchronous reset while a dump beat is stalled.
        prog_len = 10'd1; run_cycles = 32'd2; dump_base = 64'h80; dump_len = 11'd2;
        bus.dp_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_data = 32'hCAFE_0001;
        step();
        bus.ld_valid = 1'b0;
        for (int w = 0; w < 20 && !bus.dp_valid; w++) step();
        chk("arst_reached_dump_out", 64'(bus.dp_valid), 64'd1);
        #2 arst = 1'b1;
        #1;
        chk_idle("arst");
        @(posedge clk);
        #1 arst = 1'b0;
        run_job("after_arst", 2, 32'd4, 64'h40, 1, 2, 1, 64'h4, 1'b0, 0, 0);

        // Random jobs against the counting model.
        for (int r = 0; r < 12; r++) begin
            int          p, d;
            logic [31:0] rc;
            logic [63:0] b;
            p  = $urandom_range(0, 12);
            d  = $urandom_range(0, 8);
            rc = 32'($urandom_range(0, 20));
            b  = {$urandom, $urandom};
            run_job($sformatf("rnd%0d", r), p, rc, b, d,
                    (p > 512) ? 512 : p, (d > 1024) ? 1024 : d,
                    (p > 0) ? 64'(4 * (p - 1)) : 64'd0, 1'b0, 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
